// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - run-time-programmable serial pattern detector with match counter
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_din, i_din_valid serial bit and its qualifier
//   i_overlap          1 = overlapping matches, 0 = matched bits are consumed
//   i_cfg_load         latch i_cfg_pattern / i_cfg_len (length clamped to 1..MAX_LEN)
//   i_cfg_pattern      bit [len-1] is the first bit received, bit [0] the last
//   i_cfg_len          new pattern length
//   i_count_clr        clear o_match_count (wins over a simultaneous match)
//   o_match            combinational strobe in the cycle the final pattern bit arrives
//   o_match_count      saturating match counter
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0001_1011,
    parameter int                 RST_LEN     = 5,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_din,
    input  logic               i_din_valid,
    input  logic               i_overlap,
    input  logic               i_cfg_load,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_count_clr,
    output logic               o_match,
    output logic [CNT_W-1:0]   o_match_count
);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_cand;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_eq;
    logic               w_fill_ok;
    logic               w_match;
    logic [LEN_W-1:0]   w_len_clamped;
    logic [LEN_W-1:0]   w_fill_next;
    logic               w_cnt_sat;

    // Newest bit sits at [0]; the oldest relevant bit is at [len-1].
    assign w_cand = {r_hist, i_din};

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            w_mask[k] = (k < int'(r_len));
        end
    end

    assign w_eq      = (((w_cand ^ r_pattern) & w_mask) == '0);
    // Enough bits seen once the current one is counted; extra bit avoids wrap.
    assign w_fill_ok = (({1'b0, r_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len});
    assign w_match   = i_din_valid & ~i_cfg_load & ~i_rst & w_fill_ok & w_eq;
    assign o_match   = w_match;

    always_comb begin
        w_len_clamped = i_cfg_len;
        if (i_cfg_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (int'(i_cfg_len) > MAX_LEN) begin
            w_len_clamped = LEN_W'(MAX_LEN);
        end
    end

    assign w_fill_next = (int'(r_fill) >= MAX_LEN) ? LEN_W'(MAX_LEN) : (r_fill + LEN_W'(1));
    assign w_cnt_sat   = (r_count == {CNT_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pattern <= RST_PATTERN;
            r_len     <= LEN_W'(RST_LEN);
            r_hist    <= '0;
            r_fill    <= '0;
            r_count   <= '0;
        end else begin
            if (i_cfg_load) begin
                r_pattern <= i_cfg_pattern;
                r_len     <= w_len_clamped;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (i_din_valid) begin
                if (w_match && !i_overlap) begin
                    // Non-overlap: the matched bits cannot contribute to the next match.
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_cand[MAX_LEN-2:0];
                    r_fill <= w_fill_next;
                end
            end

            if (i_count_clr) begin
                r_count <= '0;
            end else if (w_match && !w_cnt_sat) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_match_count = r_count;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               din;
    logic               din_valid;
    logic               overlap;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               count_clr;
    logic               match;
    logic [7:0]         match_count;
    logic               match_c2;
    logic [1:0]         match_count_c2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_din         (din),
        .i_din_valid   (din_valid),
        .i_overlap     (overlap),
        .i_cfg_load    (cfg_load),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_count_clr   (count_clr),
        .o_match       (match),
        .o_match_count (match_count)
    );

    seq_detect_param #(.CNT_W(2)) u_dut_c2 (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_din         (din),
        .i_din_valid   (din_valid),
        .i_overlap     (overlap),
        .i_cfg_load    (cfg_load),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_count_clr   (count_clr),
        .o_match       (match_c2),
        .o_match_count (match_count_c2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one valid bit, check the combinational strobe, then let the edge happen.
    task automatic send_bit(input logic b, input logic exp_match, input string tag);
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        #1;
        check(tag, int'(match), int'(exp_match));
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Send n bits, first-sent bit at index n-1; expected strobes in the same order.
    task automatic run_stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                              input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input string tag);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        din         = pat[0];
        din_valid   = 1'b1;
        #1;
        check({tag, "_ld_nomatch"}, int'(match), 0);
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; overlap = 1'b0;
        cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; count_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_count", int'(match_count), 0);
        check("rst_match", int'(match), 0);

        // Default 11011, non-overlap then overlap
        overlap = 1'b0;
        run_stream(16'b11011011, 16'b00001000, 8, "novl");
        @(negedge clk);
        check("novl_count", int'(match_count), 1);
        do_reset();
        overlap = 1'b1;
        run_stream(16'b11011011, 16'b00001001, 8, "ovl");
        @(negedge clk);
        check("ovl_count", int'(match_count), 2);

        // Pattern 101, length 3
        load_cfg(8'b101, 4'd3, "p101");
        check("p101_count_kept", int'(match_count), 2);
        overlap = 1'b1;
        run_stream(16'b10101, 16'b00101, 5, "p101_ovl");
        load_cfg(8'b101, 4'd3, "p101b");
        overlap = 1'b0;
        run_stream(16'b10101, 16'b00100, 5, "p101_novl");

        // Default pattern with valid gaps filled with junk
        do_reset();
        overlap = 1'b0;
        begin
            logic [4:0] gbits;
            gbits = 5'b11011;
            for (int i = 4; i >= 0; i--) begin
                send_bit(gbits[i], (i == 0), $sformatf("gap_b%0d", 5 - i));
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    din       = 1'($urandom_range(1));
                    din_valid = 1'b0;
                    #1;
                    check("gap_idle", int'(match), 0);
                end
            end
        end
        @(negedge clk);
        check("gap_count", int'(match_count), 1);

        // Saturation on the 2-bit counter instance, len 1
        do_reset();
        load_cfg(8'h01, 4'd1, "sat");
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 1'b1, "sat_match");
            check($sformatf("sat_cnt%0d", i + 1), int'(match_count_c2), (i < 3) ? i + 1 : 3);
        end
        check("sat_main_cnt", int'(match_count), 5);
        count_clr = 1'b1;
        send_bit(1'b1, 1'b1, "clr_match");
        count_clr = 1'b0;
        check("clr_c2", int'(match_count_c2), 0);
        check("clr_main", int'(match_count), 0);

        // Reset mid-pattern discards history
        do_reset();
        overlap = 1'b0;
        run_stream(16'b1101, 16'b0000, 4, "pre_rst");
        @(negedge clk);
        rst       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        #1;
        check("rst_strobe", int'(match), 0);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
        send_bit(1'b1, 1'b0, "post_rst");
        @(negedge clk);
        check("post_rst_count", int'(match_count), 0);

        // Length clamps
        load_cfg(8'h01, 4'd0, "len0");
        run_stream(16'b101, 16'b101, 3, "len0");
        load_cfg(8'b1010_0110, 4'd15, "len15");
        run_stream(16'b10100110, 16'b00000001, 8, "len15");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
